// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the CPU bus
// interface and the host loader; the CPU is held off until boot completes.
module mem_port_arbiter #(
    parameter int DW           = 8,
    parameter int AW           = 8,
    parameter int READ_LATENCY = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_gnt,
    output logic          host_rvalid,
    output logic [DW-1:0] host_rdata,
    input  logic          host_boot_done,
    output logic          cpu_run,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam int CW = 2;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RD_WAIT,
        RD_DONE
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic          sel_host;
    logic          last_cpu;
    logic [CW-1:0] cnt;
    logic          take;
    logic          pick_host;
    logic          cpu_ok;

    // cpu_run doubles as the inverted boot flag so every register resets to 0
    always_comb begin
        state_nx  = state;
        take      = 1'b0;
        pick_host = 1'b0;
        cpu_ok    = cpu_req && cpu_run;
        unique case (state)
            IDLE: begin
                if (host_req || cpu_ok) begin
                    take      = 1'b1;
                    state_nx  = ISSUE;
                    pick_host = host_req && (!cpu_ok || last_cpu);
                end
            end
            ISSUE:   state_nx = mem_we ? IDLE : RD_WAIT;
            RD_WAIT: if (cnt == '0) state_nx = RD_DONE;
            RD_DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            sel_host    <= 1'b0;
            last_cpu    <= 1'b0;
            cnt         <= '0;
            cpu_run     <= 1'b0;
            cpu_gnt     <= 1'b0;
            host_gnt    <= 1'b0;
            cpu_rvalid  <= 1'b0;
            host_rvalid <= 1'b0;
            cpu_rdata   <= '0;
            host_rdata  <= '0;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nx;
            busy        <= (state_nx != IDLE);
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            cpu_gnt     <= 1'b0;
            host_gnt    <= 1'b0;
            cpu_rvalid  <= 1'b0;
            host_rvalid <= 1'b0;
            if (host_boot_done) cpu_run <= 1'b1;
            if (take) begin
                sel_host  <= pick_host;
                last_cpu  <= !pick_host;
                mem_en    <= 1'b1;
                mem_we    <= pick_host ? host_we : cpu_we;
                mem_addr  <= pick_host ? host_addr : cpu_addr;
                mem_wdata <= pick_host ? host_wdata : cpu_wdata;
                cpu_gnt   <= !pick_host;
                host_gnt  <= pick_host;
            end
            if (state == ISSUE && !mem_we) cnt <= CW'(READ_LATENCY - 1);
            if (state == RD_WAIT) begin
                if (cnt == '0) begin
                    if (sel_host) begin
                        host_rdata  <= mem_rdata;
                        host_rvalid <= 1'b1;
                    end else begin
                        cpu_rdata  <= mem_rdata;
                        cpu_rvalid <= 1'b1;
                    end
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed boot/arbitration/reset cases plus
// randomized traffic checked each cycle against a transaction-level model.
module tb_mem_port_arbiter;

    parameter int RL = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cpu_req = 1'b0, cpu_we = 1'b0;
    logic [7:0] cpu_addr = '0, cpu_wdata = '0;
    logic       cpu_gnt, cpu_rvalid;
    logic [7:0] cpu_rdata;
    logic       host_req = 1'b0, host_we = 1'b0;
    logic [7:0] host_addr = '0, host_wdata = '0;
    logic       host_gnt, host_rvalid;
    logic [7:0] host_rdata;
    logic       host_boot_done = 1'b0;
    logic       cpu_run, mem_en, mem_we, busy;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    mem_port_arbiter #(.DW(8), .AW(8), .READ_LATENCY(RL)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
        .cpu_rdata(cpu_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_gnt(host_gnt),
        .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .host_boot_done(host_boot_done), .cpu_run(cpu_run),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // memory macro with RL-cycle read pipeline
    logic [7:0] emem [256];
    logic [7:0] pipe [RL];
    initial for (int i = 0; i < 256; i++) emem[i] = 8'h00;
    initial for (int i = 0; i < RL; i++) pipe[i] = 8'h00;
    always @(posedge clk) begin
        if (mem_en && mem_we) emem[mem_addr] <= mem_wdata;
        pipe[0] <= mem_en ? emem[mem_addr] : 8'h00;
        for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_rdata = pipe[RL-1];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // transaction-level model: one transaction scheduled by edge number
    int         ed = 0, nxt = 0, a_start = -100;
    bit         act = 0, a_host = 0, a_we = 0, c_ok = 0;
    logic [7:0] a_addr = 0, a_wdata = 0, a_data = 0;
    bit         m_boot = 1, m_last_host = 1;
    logic [7:0] mmem [256];
    bit         e_cgnt = 0, e_hgnt = 0, e_crv = 0, e_hrv = 0;
    bit         e_en = 0, e_we = 0, e_busy = 0;
    logic [7:0] e_crd = 0, e_hrd = 0;
    initial for (int i = 0; i < 256; i++) mmem[i] = 8'h00;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_boot = 1; m_last_host = 1; act = 0; nxt = 0;
            e_cgnt = 0; e_hgnt = 0; e_crv = 0; e_hrv = 0;
            e_en = 0; e_we = 0; e_busy = 0; e_crd = 0; e_hrd = 0;
        end else begin
            ed++;
            if (act && a_we && ed == a_start + 1) mmem[a_addr] = a_wdata;
            if (ed >= nxt) begin
                c_ok = cpu_req && !m_boot;
                if (host_req || c_ok) begin
                    if (host_req && c_ok) a_host = !m_last_host;
                    else a_host = host_req;
                    a_we    = a_host ? host_we : cpu_we;
                    a_addr  = a_host ? host_addr : cpu_addr;
                    a_wdata = a_host ? host_wdata : cpu_wdata;
                    act = 1; a_start = ed; m_last_host = a_host;
                    if (a_we) nxt = ed + 2;
                    else begin a_data = mmem[a_addr]; nxt = ed + 3 + RL; end
                end
            end
            if (host_boot_done) m_boot = 0;
            e_en   = act && ed == a_start;
            e_cgnt = e_en && !a_host;
            e_hgnt = e_en && a_host;
            e_we   = e_en && a_we;
            e_busy = act && (ed - a_start) <= (a_we ? 0 : RL + 1);
            e_crv  = act && !a_we && !a_host && ed == a_start + RL + 1;
            e_hrv  = act && !a_we && a_host && ed == a_start + RL + 1;
            if (e_crv) e_crd = a_data;
            if (e_hrv) e_hrd = a_data;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cpu_gnt", 64'(cpu_gnt), 64'(e_cgnt));
            chk("host_gnt", 64'(host_gnt), 64'(e_hgnt));
            chk("cpu_rvalid", 64'(cpu_rvalid), 64'(e_crv));
            chk("host_rvalid", 64'(host_rvalid), 64'(e_hrv));
            chk("cpu_rdata", 64'(cpu_rdata), 64'(e_crd));
            chk("host_rdata", 64'(host_rdata), 64'(e_hrd));
            chk("cpu_run", 64'(cpu_run), 64'(!m_boot));
            chk("mem_en", 64'(mem_en), 64'(e_en));
            chk("mem_we", 64'(mem_we), 64'(e_we));
            chk("busy", 64'(busy), 64'(e_busy));
            if (e_en) chk("mem_addr", 64'(mem_addr), 64'(a_addr));
            if (e_we) chk("mem_wdata", 64'(mem_wdata), 64'(a_wdata));
        end
    end

    int n_cgnt = 0, n_we = 0, n_crv = 0;
    always @(negedge clk) begin
        n_cgnt += int'(cpu_gnt);
        n_we   += int'(mem_we);
        n_crv  += int'(cpu_rvalid);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_gnt(input bit host, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(host ? host_gnt : cpu_gnt) && n < 20);
        #1;
    endtask

    task automatic wait_rv(input bit host, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(host ? host_rvalid : cpu_rvalid) && n < 20);
        #1;
    endtask

    int       n, rv_before;
    bit [3:0] seq;

    initial begin
        @(negedge clk);
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;

        // boot: CPU request stays pending
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
        repeat (4) step();
        chk("boot_cpu_run", 64'(cpu_run), 64'd0);
        chk("boot_busy", 64'(busy), 64'd0);
        chk("boot_no_cpu_gnt", 64'(n_cgnt), 64'd0);

        host_req = 1; host_we = 1; host_addr = 8'h10; host_wdata = 8'hA5;
        wait_gnt(1, n);
        chk("host_wr_gnt_lat", 64'(n), 64'd1);
        host_req = 0;
        step();
        host_req = 1; host_we = 0;
        wait_gnt(1, n);
        chk("host_rd_gnt_lat", 64'(n), 64'd1);
        host_req = 0;
        wait_rv(1, n);
        chk("host_rd_rv_lat", 64'(n), 64'(RL + 1));
        chk("host_rd_data", 64'(host_rdata), 64'hA5);
        chk("host_wr_we_cycles", 64'(n_we), 64'd1);

        // release the CPU
        host_boot_done = 1;
        step();
        host_boot_done = 0;
        chk("release_cpu_run", 64'(cpu_run), 64'd1);
        wait_gnt(0, n);
        chk("release_cpu_gnt", 64'(cpu_gnt), 64'd1);
        cpu_req = 0;
        wait_rv(0, n);
        chk("release_cpu_rv_lat", 64'(n), 64'(RL + 1));
        chk("release_cpu_data", 64'(cpu_rdata), 64'hA5);

        // both held: CPU won last, so host leads the alternation
        cpu_req = 1; cpu_we = 1; cpu_addr = 8'h20; cpu_wdata = 8'h11;
        host_req = 1; host_we = 1; host_addr = 8'h21; host_wdata = 8'h22;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!(cpu_gnt || host_gnt) && n < 20);
            seq[i] = host_gnt;
            #1;
        end
        chk("alternation", 64'(seq), 64'h5);
        cpu_req = 0; host_req = 0;
        repeat (2) step();

        // reset in RD_WAIT of a CPU read
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h3C;
        wait_gnt(0, n);
        cpu_req = 0;
        step();
        rv_before = n_crv;
        rst = 1;
        #1;
        chk("rst_outputs_zero",
            64'({cpu_gnt, cpu_rvalid, cpu_rdata, host_gnt, host_rvalid,
                 host_rdata, cpu_run, mem_en, mem_we, mem_addr, mem_wdata,
                 busy}), 64'd0);
        repeat (2) step();
        rst = 0;
        repeat (RL + 3) step();
        chk("rst_no_cpu_rv", 64'(n_crv), 64'(rv_before));
        chk("rst_cpu_run", 64'(cpu_run), 64'd0);

        host_req = 1; host_we = 1; host_addr = 8'h3C; host_wdata = 8'h7E;
        wait_gnt(1, n);
        host_req = 0;
        step();
        host_req = 1; host_we = 0;
        wait_gnt(1, n);
        chk("post_rst_gnt_lat", 64'(n), 64'd1);
        host_req = 0;
        wait_rv(1, n);
        chk("post_rst_rv_lat", 64'(n), 64'(RL + 1));
        chk("post_rst_data", 64'(host_rdata), 64'h7E);

        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            step();
            host_boot_done = (c == 100 || c == 900 ||
                              $urandom_range(0, 199) == 0);
            if (c == 800) rst = 1;
            if (c == 803) rst = 0;
            if (cpu_req && cpu_gnt) cpu_req = 0;
            else if (!cpu_req && $urandom_range(0, 2) == 0) begin
                cpu_req   = 1;
                cpu_we    = 1'($urandom_range(0, 1));
                cpu_addr  = 8'($urandom_range(0, 15));
                cpu_wdata = 8'($urandom);
            end
            if (host_req && host_gnt) host_req = 0;
            else if (!host_req && $urandom_range(0, 2) == 0) begin
                host_req   = 1;
                host_we    = 1'($urandom_range(0, 1));
                host_addr  = 8'($urandom_range(0, 15));
                host_wdata = 8'($urandom);
            end
        end
        host_boot_done = 0;
        repeat (RL + 4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
